// File: rtl/mul_limb_seq.sv
// Limb-serial multiplier: one LIMB_W x LIMB_W partial product per cycle.
// Define MUL_LIMB_SEQ_SIGNED_EN for two's-complement operands (adds NEG).
module mul_limb_seq #(
    parameter int LIMB_W = 12,
    parameter int LIMBS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LIMB_W*LIMBS-1:0]   input0,
    input  logic [LIMB_W*LIMBS-1:0]   input1,
    output logic                      busy,
    output logic                      ready,
    output logic                      done,
    output logic [2*LIMB_W*LIMBS-1:0] output0
);
    localparam int W  = LIMB_W * LIMBS;
    localparam int PW = 2 * W;
    localparam int CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

`ifdef MUL_LIMB_SEQ_SIGNED_EN
    typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

    state_t state, state_nx;

    logic [W-1:0]        a_q, b_q;
    logic [W-1:0]        a_in, b_in;
    logic [PW-1:0]       acc;
    logic [CW-1:0]       i_q, j_q;
    logic [LIMB_W-1:0]   a_limb, b_limb;
    logic [2*LIMB_W-1:0] pp;
    logic [PW-1:0]       pp_sh;
    logic                last;

`ifdef MUL_LIMB_SEQ_SIGNED_EN
    logic neg_q;
    logic sgn_in;

    // -2^(W-1) negates to itself, which reads correctly as unsigned
    assign a_in   = input0[W-1] ? -input0 : input0;
    assign b_in   = input1[W-1] ? -input1 : input1;
    assign sgn_in = input0[W-1] ^ input1[W-1];
`else
    assign a_in = input0;
    assign b_in = input1;
`endif

    assign busy = (state != IDLE);
    assign last = (i_q == LAST) && (j_q == LAST);

    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int k = 0; k < LIMBS; k++) begin
            if (i_q == CW'(k)) a_limb = a_q[k*LIMB_W +: LIMB_W];
            if (j_q == CW'(k)) b_limb = b_q[k*LIMB_W +: LIMB_W];
        end
        pp = {{LIMB_W{1'b0}}, a_limb} * {{LIMB_W{1'b0}}, b_limb};
        pp_sh = '0;
        for (int k = 0; k < 2*LIMBS-1; k++) begin
            if ({1'b0, i_q} + {1'b0, j_q} == (CW+1)'(k))
                pp_sh = PW'(pp) << (k*LIMB_W);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = CALC;
`ifdef MUL_LIMB_SEQ_SIGNED_EN
            CALC: if (last) state_nx = NEG;
            NEG:  state_nx = DONE;
`else
            CALC: if (last) state_nx = DONE;
`endif
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            ready   <= 1'b0;
            done    <= 1'b0;
            output0 <= '0;
`ifdef MUL_LIMB_SEQ_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a_in;
                        b_q   <= b_in;
                        acc   <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        ready <= 1'b0;
`ifdef MUL_LIMB_SEQ_SIGNED_EN
                        neg_q <= sgn_in;
`endif
                    end
                end
                CALC: begin
                    acc <= acc + pp_sh;
                    if (i_q == LAST) begin
                        i_q <= '0;
                        j_q <= j_q + 1'b1;
                    end else begin
                        i_q <= i_q + 1'b1;
                    end
                end
`ifdef MUL_LIMB_SEQ_SIGNED_EN
                NEG: if (neg_q) acc <= -acc;
`endif
                DONE: begin
                    output0 <= acc;
                    ready   <= 1'b1;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_limb_seq.sv
// Randomised bench for mul_limb_seq: default 12x2 instance plus an 8x4 one.
// Expected products come from plain wide arithmetic on the operands.
module tb_mul_limb_seq;
    localparam int W = 24;
`ifdef MUL_LIMB_SEQ_SIGNED_EN
    localparam int LAT  = 6;
    localparam int LAT8 = 18;
`else
    localparam int LAT  = 5;
    localparam int LAT8 = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic [23:0] input0 = '0;
    logic [23:0] input1 = '0;
    logic [31:0] a8 = '0;
    logic [31:0] b8 = '0;
    logic        busy, ready, done;
    logic        busy8, ready8, done8;
    logic [47:0] output0;
    logic [63:0] out8;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_acc = -1;

    mul_limb_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input0(input0), .input1(input1),
        .busy(busy), .ready(ready), .done(done),
        .output0(output0)
    );

    mul_limb_seq #(.LIMB_W(8), .LIMBS(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .input0(a8), .input1(b8),
        .busy(busy8), .ready(ready8), .done(done8),
        .output0(out8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact product of w-bit operands, truncated to 2w bits
    function automatic logic [63:0] mref(input logic [31:0] a,
                                         input logic [31:0] b, input int w);
        logic [63:0] ea, eb, m;
        m  = (64'd1 << (2*w)) - 64'd1;
        ea = {32'd0, a};
        eb = {32'd0, b};
`ifdef MUL_LIMB_SEQ_SIGNED_EN
        if (a[w-1]) ea = ea | (~64'd0 << w);
        if (b[w-1]) eb = eb | (~64'd0 << w);
`endif
        return (ea * eb) & m;
    endfunction

    task automatic run(input logic [23:0] a, input logic [23:0] b,
                       input bit poke, input bit chain, input string tag);
        logic [63:0] e;
        int n, dn;
        e = mref({8'd0, a}, {8'd0, b}, W);
        @(negedge clk);
        start  = 1'b1;
        input0 = a;
        input1 = b;
        @(posedge clk);
        #1;
        if (chain && last_acc >= 0)
            check({tag, "_tput"}, 64'(cyc - last_acc), 64'(LAT + 1));
        last_acc = cyc;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "_rdy_clr"}, {63'd0, ready}, 64'd0);
        check({tag, "_done_lo"}, {63'd0, done}, 64'd0);
        start  = poke;
        input0 = poke ? 24'd0 : 24'($urandom);
        input1 = poke ? 24'd0 : 24'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start  = poke && (n < 3);
            input0 = (poke && n < 3) ? 24'd0 : 24'($urandom);
            input1 = (poke && n < 3) ? 24'd0 : 24'($urandom);
        end while (!done && n < 40);
        check({tag, "_lat"}, 64'(n), 64'(LAT));
        check({tag, "_prod"}, {16'd0, output0}, e);
        check({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
        if (!chain) begin
            dn = 0;
            repeat (LAT + 2) begin
                @(posedge clk);
                #1;
                dn += int'(done);
            end
            check({tag, "_pulses"}, 64'(dn), 64'd0);
            check({tag, "_hold"}, {16'd0, output0}, e);
            check({tag, "_rdy_hold"}, {63'd0, ready}, 64'd1);
            last_acc = -1;
        end
    endtask

    task automatic run8(input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        logic [63:0] e;
        int n;
        e = mref(a, b, 32);
        @(negedge clk);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check({tag, "_busy"}, {63'd0, busy8}, 64'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            a8 = $urandom;
            b8 = $urandom;
        end while (!done8 && n < 60);
        check({tag, "_lat"}, 64'(n), 64'(LAT8));
        check({tag, "_prod"}, out8, e);
        check({tag, "_ready"}, {63'd0, ready8}, 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", {16'd0, output0}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;

        run(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, "ff_sq");
        run(24'h000FFF, 24'h001000, 1'b1, 1'b0, "poke");
        run(24'h800000, 24'h000001, 1'b0, 1'b0, "min_x1");
        run(24'h800000, 24'h800000, 1'b0, 1'b0, "min_sq");
        run(24'h000000, 24'hABCDEF, 1'b0, 1'b0, "zero");
        for (int k = 0; k < 20; k++)
            run(24'($urandom), 24'($urandom), 1'b0, 1'b1, "rnd");

        @(negedge clk);
        start  = 1'b1;
        input0 = 24'd7;
        input1 = 24'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {16'd0, output0}, 64'd0);
        check("mid_rst_ready", {63'd0, ready}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(24'd3, 24'd5, 1'b0, 1'b0, "post_rst");

        run8(32'hFFFFFFFF, 32'hFFFFFFFF, "w8_ff");
        run8(32'h80000000, 32'h00000001, "w8_min");
        for (int k = 0; k < 4; k++)
            run8($urandom, $urandom, "w8_rnd");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
